div_share_arbiter: RTL

//  Shares one sequential divider unit (controller + datapath) among N_REQ requesters.
//  - Round-robin grant; latches the winner's operands.
//  - Issues a one-cycle start, then tracks the divider's busy/valid/ovf handshake.
//  - Returns quotient plus completion status to the granted requester only.
//  - Sits between client blocks and the divider top; the divider keeps its own start/busy protocol.

---
 rtl/div_share_arbiter_pkg.sv | 20 ++
 rtl/div_share_arbiter_rr_pick.sv | 32 +++
 rtl/div_share_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/div_share_arbiter_pkg.sv
// Shared types for the divider-sharing arbiter: FSM state encoding and
// completion status codes returned to the requester.
package div_arb_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        RUN       = 3'd3,
        DONE      = 3'd4
    } arb_state_e;

    typedef enum logic [1:0] {
        ST_OK  = 2'b00,
        ST_OVF = 2'b01,
        ST_DVZ = 2'b10,
        ST_TMO = 2'b11
    } arb_status_e;

endpackage

// File: rtl/div_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr,
// wrapping, returned both one-hot and as an index.
module rr_priority_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req_i,
    input  logic [$clog2(N_REQ)-1:0] ptr_i,
    output logic [N_REQ-1:0]         pick_o,
    output logic [$clog2(N_REQ)-1:0] idx_o
);
    localparam int IW = $clog2(N_REQ);

    logic found;
    int   j;

    always_comb begin
        pick_o = '0;
        idx_o  = '0;
        found  = 1'b0;
        j      = 0;
        // k = N_REQ revisits ptr itself last, so a lone requester at ptr still wins
        for (int k = 1; k <= N_REQ; k++) begin
            j = (int'(ptr_i) + k) % N_REQ;
            if (!found && req_i[j]) begin
                found     = 1'b1;
                pick_o[j] = 1'b1;
                idx_o     = IW'(j);
            end
        end
    end

endmodule

// File: rtl/div_share_arbiter.sv
// Round-robin arbiter sharing one sequential divider among N_REQ clients:
// grants, latches operands, issues start and tracks busy/valid/ovf to completion.
module div_share_arbiter
    import div_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 10,
    parameter int TMO   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] a_bus,
    input  logic [N_REQ*WIDTH-1:0] b_bus,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic [WIDTH-1:0]       res_q,
    output logic [1:0]             res_st,
    output logic                   div_start,
    output logic [WIDTH-1:0]       div_a,
    output logic [WIDTH-1:0]       div_b,
    input  logic                   div_busy,
    input  logic                   div_valid,
    input  logic                   div_ovf,
    input  logic [WIDTH-1:0]       div_q
);
    localparam int IW = $clog2(N_REQ);
    localparam int TW = $clog2(TMO + 1);

    arb_state_e        state_q, state_d;
    arb_status_e       status_q, status_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]  resq_q, resq_d;
    logic              ovf_seen_q, ovf_seen_d;
    logic              valid_seen_q, valid_seen_d;
    logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;

    logic [N_REQ-1:0]  pick;
    logic [IW-1:0]     pick_idx;

    rr_priority_pick #(.N_REQ(N_REQ)) u_pick (
        .req_i  (req),
        .ptr_i  (ptr_q),
        .pick_o (pick),
        .idx_o  (pick_idx)
    );

    always_comb begin
        state_d      = state_q;
        status_d     = status_q;
        gnt_d        = gnt_q;
        ptr_d        = ptr_q;
        a_d          = a_q;
        b_d          = b_q;
        resq_d       = resq_q;
        ovf_seen_d   = ovf_seen_q;
        valid_seen_d = valid_seen_q;
        tmo_cnt_d    = tmo_cnt_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d   = pick;
                    ptr_d   = pick_idx;
                    a_d     = a_bus[int'(pick_idx)*WIDTH +: WIDTH];
                    b_d     = b_bus[int'(pick_idx)*WIDTH +: WIDTH];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                ovf_seen_d   = 1'b0;
                valid_seen_d = 1'b0;
                tmo_cnt_d    = '0;
                state_d      = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (div_busy) begin
                    state_d = RUN;
                end else if (tmo_cnt_q == TW'(TMO - 1)) begin
                    status_d = ST_TMO;
                    state_d  = DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            RUN: begin
                ovf_seen_d = ovf_seen_q | div_ovf;
                if (div_valid) begin
                    resq_d       = div_q;
                    valid_seen_d = 1'b1;
                end
                // Fold in this cycle's flags so a valid/ovf coinciding with busy fall counts
                if (!div_busy) begin
                    if (valid_seen_q || div_valid)    status_d = ST_OK;
                    else if (ovf_seen_q || div_ovf)   status_d = ST_OVF;
                    else                              status_d = ST_DVZ;
                    state_d = DONE;
                end
            end
            DONE: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            status_q     <= ST_OK;
            gnt_q        <= '0;
            ptr_q        <= IW'(N_REQ - 1);
            a_q          <= '0;
            b_q          <= '0;
            resq_q       <= '0;
            ovf_seen_q   <= 1'b0;
            valid_seen_q <= 1'b0;
            tmo_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            status_q     <= status_d;
            gnt_q        <= gnt_d;
            ptr_q        <= ptr_d;
            a_q          <= a_d;
            b_q          <= b_d;
            resq_q       <= resq_d;
            ovf_seen_q   <= ovf_seen_d;
            valid_seen_q <= valid_seen_d;
            tmo_cnt_q    <= tmo_cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = (state_q == DONE) ? gnt_q : '0;
    assign div_start = (state_q == ISSUE) && !div_busy;
    assign div_a     = a_q;
    assign div_b     = b_q;
    assign res_q     = resq_q;
    assign res_st    = status_q;

endmodule
